blue_centroid: RTL and testbench
================================

// Module: blue_centroid
// PURPOSE
//  Consumes the per-pixel bluecheck flag from the colour classifier and, per video frame,
//  counts flagged pixels and sums their X/Y coordinates. At frame end it snapshots the
//  totals and computes the target centroid with a shared-cycle sequential restoring divider.
//  Sits directly downstream of the classifier; feeds the tracking/overlay logic.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line; frame end = (H_ACTIVE-1, V_ACTIVE-1)
//  V_ACTIVE   480  active lines per frame
//  MIN_COUNT  64   minimum flagged pixels for a valid target (must be >= 1)
//  CNT_W      19   pixel counter width (holds H_ACTIVE*V_ACTIVE)
//  SUM_W      29   coordinate-sum width; also the divider iteration count
// PORTS
//  clk          in   1      pixel clock, same clock as classifier
//  reset        in   1      asynchronous, active-high
//  pixel_valid  in   1      x_in/y_in are an active-area pixel this cycle
//  x_in         in   10     column of pixel presented to classifier this cycle
//  y_in         in   10     row of pixel presented to classifier this cycle
//  bluecheck    in   1      classifier flag; registered, 1 cycle behind x_in/y_in
//  centroid_x   out  10     truncated mean X of flagged pixels, last valid frame
//  centroid_y   out  10     truncated mean Y of flagged pixels, last valid frame
//  pixel_count  out  CNT_W  flagged-pixel count of last completed frame
//  target_found out  1      pixel_count >= MIN_COUNT for last completed frame
//  result_valid out  1      one-cycle pulse: outputs above just updated
//  busy         out  1      high while state != IDLE
//  overrun      out  1      one-cycle pulse: frame end arrived while busy
// BEHAVIOUR
//  - Reset (async, dominates all events): every output 0, accumulators 0, state IDLE.
//  - Alignment: pixel_valid/x_in/y_in registered once (valid_d/x_d/y_d) to align with bluecheck.
//  - Accumulate on every edge with valid_d && bluecheck: cnt+=1, sx+=x_d, sy+=y_d.
//    Flag with valid_d=0 (blanking) is ignored. Accumulation never stops, in any state.
//  - Frame end = valid_d && x_d==H_ACTIVE-1 && y_d==V_ACTIVE-1. On that edge the totals
//    INCLUDING the last pixel's flag are snapshotted and accumulators cleared to 0.
//  - FSM IDLE -> DIVIDE | DONE -> IDLE:
//    IDLE, frame end: load snapshot; cnt < MIN_COUNT -> DONE (skip divide), else -> DIVIDE,
//      iteration counter = SUM_W.
//    DIVIDE: sx/cnt and sy/cnt in parallel, one quotient bit per cycle, MSB first,
//      restoring, truncating; SUM_W cycles, then -> DONE.
//    DONE (1 cycle): result_valid=1; pixel_count, target_found updated; centroid_x/y take the
//      quotient low 10 bits only if target_found, else hold previous values. -> IDLE.
//  - Latency (cycle 0 = last pixel on x_in): snapshot at end of cycle 1; divide cycles
//    2..SUM_W+1; result_valid in cycle SUM_W+2 (31 default); skip path result_valid cycle 2.
//  - Frame end while DIVIDE/DONE: snapshot dropped, accumulators still cleared, overrun
//    pulses one cycle, in-progress result unaffected.
//  - Widths: sums never wrap for the default geometry (max 98,150,400 < 2^29); quotient
//    is always < H_ACTIVE, so upper quotient bits are zero.
// TESTING
//  1. MIN_COUNT=1, one flagged pixel (100,50) -> count 1, found 1, centroid (100,50),
//     result_valid only in cycle 31.
//  2. Flag block x 200..209, y 300..309 -> count 100, centroid (204,304), found 1.
//  3. Frame with no flags after test 2 -> count 0, found 0, centroid holds (204,304),
//     result_valid in cycle 2, divider not entered (busy high 1 cycle).
//  4. All 307200 pixels flagged -> count 307200, centroid (319,239), no sum overflow.
//  5. bluecheck=1 during blanking (pixel_valid=0) for 1000 cycles -> count unaffected.
//  6. Reset asserted mid-DIVIDE -> outputs 0 immediately, IDLE; next frame matches test 2.
//     Also force frame end during DIVIDE -> overrun pulse, first result still correct.

Source files
------------

// File: rtl/blue_centroid.sv
// Per-frame accumulator for classifier-flagged pixels with a sequential restoring divider
// that turns the frame totals into a truncated X/Y centroid.
module blue_centroid #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MIN_COUNT = 64,
  parameter int CNT_W     = 19,
  parameter int SUM_W     = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_valid,
  input  logic [9:0]       x_in,
  input  logic [9:0]       y_in,
  input  logic             bluecheck,
  output logic [9:0]       centroid_x,
  output logic [9:0]       centroid_y,
  output logic [CNT_W-1:0] pixel_count,
  output logic             target_found,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int IT_W = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIVIDE = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  logic             r_valid_d;
  logic [9:0]       r_x_d;
  logic [9:0]       r_y_d;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_sx;
  logic [SUM_W-1:0] r_sy;
  logic [CNT_W-1:0] r_div_cnt;
  logic [SUM_W-1:0] r_qx;
  logic [SUM_W-1:0] r_qy;
  logic [CNT_W-1:0] r_remx;
  logic [CNT_W-1:0] r_remy;
  logic [IT_W-1:0]  r_iter;
  logic [9:0]       r_centroid_x;
  logic [9:0]       r_centroid_y;
  logic [CNT_W-1:0] r_pixel_count;
  logic             r_target_found;
  logic             r_result_valid;
  logic             r_busy;
  logic             r_overrun;

  logic             w_acc;
  logic             w_frame_end;
  logic [CNT_W-1:0] w_cnt_tot;
  logic [SUM_W-1:0] w_sx_tot;
  logic [SUM_W-1:0] w_sy_tot;
  logic [CNT_W:0]   w_remx_sh;
  logic [CNT_W:0]   w_remy_sh;
  logic             w_x_ge;
  logic             w_y_ge;
  logic [CNT_W-1:0] w_remx_nx;
  logic [CNT_W-1:0] w_remy_nx;
  logic [SUM_W-1:0] w_qx_nx;
  logic [SUM_W-1:0] w_qy_nx;

  assign w_acc       = r_valid_d && bluecheck;
  assign w_frame_end = r_valid_d && (r_x_d == 10'(H_ACTIVE - 1)) && (r_y_d == 10'(V_ACTIVE - 1));

  // Snapshot totals must include the flag of the frame's final pixel
  assign w_cnt_tot = r_cnt + CNT_W'(w_acc);
  assign w_sx_tot  = r_sx + (w_acc ? SUM_W'(r_x_d) : {SUM_W{1'b0}});
  assign w_sy_tot  = r_sy + (w_acc ? SUM_W'(r_y_d) : {SUM_W{1'b0}});

  // One restoring step per cycle: dividend shifts out MSB-first, quotient bits shift in at LSB
  assign w_remx_sh = {r_remx, r_qx[SUM_W-1]};
  assign w_remy_sh = {r_remy, r_qy[SUM_W-1]};
  assign w_x_ge    = w_remx_sh >= {1'b0, r_div_cnt};
  assign w_y_ge    = w_remy_sh >= {1'b0, r_div_cnt};
  assign w_remx_nx = w_x_ge ? CNT_W'(w_remx_sh - {1'b0, r_div_cnt}) : w_remx_sh[CNT_W-1:0];
  assign w_remy_nx = w_y_ge ? CNT_W'(w_remy_sh - {1'b0, r_div_cnt}) : w_remy_sh[CNT_W-1:0];
  assign w_qx_nx   = {r_qx[SUM_W-2:0], w_x_ge};
  assign w_qy_nx   = {r_qy[SUM_W-2:0], w_y_ge};

  // Coordinate alignment with the classifier flag, and free-running frame accumulators
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_d <= 1'b0;
      r_x_d     <= 10'd0;
      r_y_d     <= 10'd0;
      r_cnt     <= {CNT_W{1'b0}};
      r_sx      <= {SUM_W{1'b0}};
      r_sy      <= {SUM_W{1'b0}};
    end else begin
      r_valid_d <= pixel_valid;
      r_x_d     <= x_in;
      r_y_d     <= y_in;
      if (w_frame_end) begin
        r_cnt <= {CNT_W{1'b0}};
        r_sx  <= {SUM_W{1'b0}};
        r_sy  <= {SUM_W{1'b0}};
      end else if (w_acc) begin
        r_cnt <= w_cnt_tot;
        r_sx  <= w_sx_tot;
        r_sy  <= w_sy_tot;
      end
    end
  end

  // Result FSM: snapshot, divide, publish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_div_cnt      <= {CNT_W{1'b0}};
      r_qx           <= {SUM_W{1'b0}};
      r_qy           <= {SUM_W{1'b0}};
      r_remx         <= {CNT_W{1'b0}};
      r_remy         <= {CNT_W{1'b0}};
      r_iter         <= {IT_W{1'b0}};
      r_centroid_x   <= 10'd0;
      r_centroid_y   <= 10'd0;
      r_pixel_count  <= {CNT_W{1'b0}};
      r_target_found <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_overrun      <= w_frame_end && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_frame_end) begin
            r_div_cnt <= w_cnt_tot;
            r_qx      <= w_sx_tot;
            r_qy      <= w_sy_tot;
            r_remx    <= {CNT_W{1'b0}};
            r_remy    <= {CNT_W{1'b0}};
            r_iter    <= IT_W'(SUM_W);
            r_busy    <= 1'b1;
            if (w_cnt_tot < CNT_W'(MIN_COUNT)) begin
              r_pixel_count  <= w_cnt_tot;
              r_target_found <= 1'b0;
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          r_qx   <= w_qx_nx;
          r_qy   <= w_qy_nx;
          r_remx <= w_remx_nx;
          r_remy <= w_remy_nx;
          r_iter <= r_iter - IT_W'(1);
          if (r_iter == IT_W'(1)) begin
            r_centroid_x   <= w_qx_nx[9:0];
            r_centroid_y   <= w_qy_nx[9:0];
            r_pixel_count  <= r_div_cnt;
            r_target_found <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign centroid_x   = r_centroid_x;
  assign centroid_y   = r_centroid_y;
  assign pixel_count  = r_pixel_count;
  assign target_found = r_target_found;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_blue_centroid.sv
// Randomized scoreboard bench for blue_centroid on a reduced 40x30 geometry.
module tb_blue_centroid;
  localparam int H = 40;
  localparam int V = 30;
  localparam int MINC = 4;
  localparam int CW = 19;
  localparam int SW = 29;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixel_valid;
  logic [9:0]    x_in;
  logic [9:0]    y_in;
  logic          bluecheck;
  logic [9:0]    centroid_x;
  logic [9:0]    centroid_y;
  logic [CW-1:0] pixel_count;
  logic          target_found;
  logic          result_valid;
  logic          busy;
  logic          overrun;

  blue_centroid #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(MINC), .CNT_W(CW), .SUM_W(SW)) dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .x_in(x_in), .y_in(y_in),
    .bluecheck(bluecheck), .centroid_x(centroid_x), .centroid_y(centroid_y),
    .pixel_count(pixel_count), .target_found(target_found), .result_valid(result_valid),
    .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  typedef struct {int cyc; int cnt; bit found; int cx; int cy;} exp_t;
  exp_t eq[$];
  int   oq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit prev_v = 1'b0;
  bit prev_f = 1'b0;
  int m_cnt = 0, m_sx = 0, m_sy = 0;
  int m_cx = 0, m_cy = 0;
  int m_free = 0;
  int rx0, rx1, ry0, ry1, dens;
  int pxq[$];
  int pyq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the frame's flagged pixels give count, mean coordinates and result timing.
  task automatic frame_end_model();
    exp_t e;
    if (cyc >= m_free) begin
      e.found = (m_cnt >= MINC);
      e.cnt   = m_cnt;
      if (e.found) begin
        m_cx = (m_sx / m_cnt) % 1024;
        m_cy = (m_sy / m_cnt) % 1024;
      end
      e.cx  = m_cx;
      e.cy  = m_cy;
      e.cyc = cyc + (e.found ? SW + 2 : 2);
      m_free = e.cyc;
      eq.push_back(e);
    end else begin
      oq.push_back(cyc + 2);
    end
    m_cnt = 0; m_sx = 0; m_sy = 0;
  endtask

  task automatic drive(input bit v, input int x, input int y, input bit f, input bit bc_blank);
    @(posedge clk); #1;
    pixel_valid = v;
    x_in = 10'(x);
    y_in = 10'(y);
    bluecheck = prev_v ? prev_f : bc_blank;
    prev_v = v;
    prev_f = f;
    if (v && f) begin m_cnt++; m_sx += x; m_sy += y; end
    if (v && x == H - 1 && y == V - 1) frame_end_model();
  endtask

  function automatic bit flag_of(input int mode, input int x, input int y);
    bit f = 1'b0;
    case (mode)
      0: foreach (pxq[i]) if (pxq[i] == x && pyq[i] == y) f = 1'b1;
      1: f = (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1);
      2: f = 1'b1;
      default: f = ($urandom_range(0, 99) < dens);
    endcase
    return f;
  endfunction

  task automatic run_frame(input int mode, input int gap_at, input int gap_len, input bit gap_bc);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (y * H + x == gap_at) repeat (gap_len) drive(1'b0, 0, 0, 1'b0, gap_bc);
        drive(1'b1, x, y, flag_of(mode, x, y), 1'b0);
        if (mode == 3 && x == H - 1 && y != V - 1)
          repeat ($urandom_range(0, 2)) drive(1'b0, 0, 0, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
    repeat (40) drive(1'b0, 0, 0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic set_rect(input int a, input int b, input int c, input int d);
    rx0 = a; rx1 = b; ry0 = c; ry1 = d;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cx"}, int'(centroid_x), 0);
    chk({tag, "_cy"}, int'(centroid_y), 0);
    chk({tag, "_cnt"}, int'(pixel_count), 0);
    chk({tag, "_found"}, int'(target_found), 0);
    chk({tag, "_rv"}, int'(result_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ovr"}, int'(overrun), 0);
  endtask

  // Monitor: pop the scoreboard whenever the DUT publishes a result or an overrun pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (result_valid) begin
        if (eq.size() == 0) begin
          chk("unexpected_result_valid", 1, 0);
        end else begin
          exp_t e;
          e = eq.pop_front();
          chk("result_cycle", cyc, e.cyc);
          chk("pixel_count", int'(pixel_count), e.cnt);
          chk("target_found", int'(target_found), int'(e.found));
          chk("centroid_x", int'(centroid_x), e.cx);
          chk("centroid_y", int'(centroid_y), e.cy);
        end
      end
      if (overrun) begin
        if (oq.size() == 0) chk("unexpected_overrun", 1, 0);
        else chk("overrun_cycle", cyc, oq.pop_front());
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; pixel_valid = 1'b0; x_in = 10'd0; y_in = 10'd0; bluecheck = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // four points, last pixel of frame among them: count == MIN_COUNT
    pxq = '{10, 12, 3, 39}; pyq = '{5, 7, 20, 29};
    run_frame(0, -1, 0, 1'b0);
    // three points: below threshold, centroid holds
    pxq = '{1, 2, 3}; pyq = '{1, 2, 3};
    run_frame(0, -1, 0, 1'b0);
    // 10x10 block, with 1000 blanking cycles of bluecheck=1 mid-frame
    set_rect(20, 29, 10, 19);
    run_frame(1, 600, 1000, 1'b1);
    // empty frame
    set_rect(1, 0, 1, 0);
    run_frame(1, -1, 0, 1'b0);
    // every pixel flagged
    run_frame(2, -1, 0, 1'b0);
    // random density frames
    for (int i = 0; i < 5; i++) begin
      dens = $urandom_range(0, 60);
      run_frame(3, -1, 0, 1'b0);
    end

    // frame end while dividing: overrun, dropped snapshot, first result intact
    set_rect(5, 14, 3, 12);
    run_frame(1, -1, 0, 1'b0);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        drive(1'b1, x, y, flag_of(1, x, y), 1'b0);
    repeat (5) drive(1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, H - 1, V - 1, 1'b1, 1'b0);
    repeat (40) drive(1'b0, 0, 0, 1'b0, 1'b0);
    dens = 30;
    run_frame(3, -1, 0, 1'b0);

    // reset in the middle of a divide
    set_rect(20, 29, 10, 19);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        drive(1'b1, x, y, flag_of(1, x, y), 1'b0);
    repeat (10) drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("busy_mid_divide", int'(busy), 1);
    @(negedge clk); #1 reset = 1'b1;
    #1 check_zero("mid_reset");
    eq.delete(); oq.delete();
    m_cnt = 0; m_sx = 0; m_sy = 0; m_cx = 0; m_cy = 0; m_free = 0; prev_v = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    run_frame(1, -1, 0, 1'b0);

    n = 0;
    while ((eq.size() != 0 || oq.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    chk("results_pending", eq.size(), 0);
    chk("overruns_pending", oq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
